tlb_l2_assoc: RTL and testbench
===============================

TLB_L2_ASSOC -- requirements
Module: tlb_l2_assoc

Interface
REQ-001 SHALL have parameter ENTRIES, default 512, meaning total entries.
REQ-002 SHALL have parameter WAYS, default 8, meaning associativity; SETS = ENTRIES/WAYS.
REQ-003 SHALL have parameter VA_W, default 64, meaning virtual address width.
REQ-004 SHALL have parameter PA_W, default 64, meaning physical address width.
REQ-005 SHALL have parameter PAGE_SHIFT, default 12, meaning page offset bits.
REQ-006 SHALL have port clk  in  1  sole clock; one clock, all state on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have ports req_valid_i in 1, req_ready_o out 1, req_vaddr_i in VA_W, req_perm_i in 3: lookup request.
REQ-009 SHALL have ports resp_valid_o out 1, resp_hit_o out 1, resp_paddr_o out PA_W, resp_fault_o out 1: lookup response.
REQ-010 SHALL have ports refill_valid_i in 1, refill_vaddr_i in VA_W, refill_paddr_i in PA_W, refill_perm_i in 3: fill.
REQ-011 SHALL have ports flush_i in 1 (start full invalidate) and flush_done_o out 1 (one-cycle pulse).

Function
REQ-012 SHALL split VPN = vaddr[VA_W-1:PAGE_SHIFT]; set index = low log2(SETS) VPN bits; tag = remaining VPN bits.
REQ-013 SHALL accept a lookup when req_valid_i && req_ready_o; response appears exactly 1 cycle later with resp_valid_o=1 for one cycle.
REQ-014 SHALL assert resp_hit_o when any valid way in the indexed set matches tag; at most one way matches by construction.
REQ-015 SHALL on hit drive resp_paddr_o = {stored PPN, req offset} and resp_fault_o = |(req_perm & ~stored perm).
REQ-016 SHALL on miss or when resp_valid_o=0 drive resp_hit_o, resp_fault_o, resp_paddr_o to 0.
REQ-017 SHALL on refill write the matching-tag way if present (update, no duplicate), else lowest-numbered invalid way, else victim way.
REQ-018 SHALL keep one log2(WAYS)-bit round-robin victim pointer per set, incremented (wrapping WAYS-1 -> 0) only when a valid entry is evicted.
REQ-019 SHALL, for lookup and refill to the same set in the same cycle, return pre-refill contents (read-before-write).
REQ-020 SHALL implement FSM IDLE -> FLUSH on flush_i in IDLE; FLUSH clears valid of one set per cycle, index 0..SETS-1, then returns to IDLE.
REQ-021 SHALL pulse flush_done_o in the cycle the last set is cleared; total flush SETS cycles.
REQ-022 SHALL hold req_ready_o=0 during FLUSH and in the cycle flush_i is accepted; req_ready_o=1 in IDLE otherwise.
REQ-023 SHALL ignore refill_valid_i and further flush_i while in FLUSH; a lookup accepted the cycle before flush starts still completes against pre-flush contents.

Reset
REQ-024 SHALL on rst_n=0 clear all valid bits, victim pointers, flush index, FSM to IDLE, resp_valid_o/resp_hit_o/resp_fault_o/flush_done_o=0, resp_paddr_o=0, req_ready_o=1 after release.
REQ-025 SHALL on reset mid-flush abandon the sweep, leave all entries invalid, and not pulse flush_done_o.

Configuration
REQ-026 SHALL with macro TLB_ASID_EN defined add ports req_asid_i, refill_asid_i in 16, flush_asid_valid_i in 1, flush_asid_i in 16; tag compare includes ASID; flush with flush_asid_valid_i=1 clears only entries of flush_asid_i.
REQ-027 SHALL without TLB_ASID_EN omit those ports and storage; flush clears all entries.

Structure
REQ-028 SHALL place the entry struct (valid, tag, PPN, perm, optional ASID), perm bit constants (R/W/X) and FSM state enum in shared package mmu_pkg.
REQ-029 SHALL use one sub-module tlb_rr_victim (per-set round-robin pointer array, invalid-way priority select).
REQ-030 SHALL reject at elaboration WAYS not a power of two or ENTRIES not a multiple of WAYS.

Verification
REQ-031 SHALL cover: refill va 0x1000 pa 0x8000 perm 3'b011, lookup va 0x1234 perm 3'b001 -> next cycle hit=1, paddr 0x8234, fault=0.
REQ-032 SHALL cover: same entry, lookup perm 3'b100 -> hit=1, fault=1; lookup va 0x2000 unfilled -> hit=0, paddr 0.
REQ-033 SHALL cover: 9 refills same set (default params, VPN stride 64) -> first refilled VPN misses, other 8 hit; 10th refill evicts way 1.
REQ-034 SHALL cover: flush_i after fills -> req_ready_o=0 for 64 cycles, flush_done_o single pulse, all subsequent lookups miss.
REQ-035 SHALL cover: same-cycle lookup and refill to same tag -> miss that cycle, hit on next lookup; rst_n low mid-flush -> no done pulse, all miss.
REQ-036 SHALL cover (TLB_ASID_EN): entries ASID 1 and 2 same VA, ASID-flush 1 -> ASID 2 hits, ASID 1 misses.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared MMU types: TLB entry layout, permission bits and flush FSM states.
// Defining TLB_ASID_EN adds an ASID field to every entry.
package mmu_pkg;

    localparam int TAG_MAX_W = 64;
    localparam int PPN_MAX_W = 64;
    localparam int ASID_W    = 16;

    localparam logic [2:0] PERM_R = 3'b001;
    localparam logic [2:0] PERM_W = 3'b010;
    localparam logic [2:0] PERM_X = 3'b100;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } tlb_state_e;

    // Tag and PPN are kept at maximum width and zero-extended on write.
    typedef struct packed {
        logic                 valid;
`ifdef TLB_ASID_EN
        logic [ASID_W-1:0]    asid;
`endif
        logic [TAG_MAX_W-1:0] tag;
        logic [PPN_MAX_W-1:0] ppn;
        logic [2:0]           perm;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_l2_assoc_if.sv
// Lookup, refill and flush bus of the L2 TLB.
// Defining TLB_ASID_EN adds the ASID signals.
interface tlb_l2_assoc_if #(
    parameter int VA_W = 64,
    parameter int PA_W = 64
);
    import mmu_pkg::*;

    logic            req_valid_i;
    logic            req_ready_o;
    logic [VA_W-1:0] req_vaddr_i;
    logic [2:0]      req_perm_i;

    logic            resp_valid_o;
    logic            resp_hit_o;
    logic [PA_W-1:0] resp_paddr_o;
    logic            resp_fault_o;

    logic            refill_valid_i;
    logic [VA_W-1:0] refill_vaddr_i;
    logic [PA_W-1:0] refill_paddr_i;
    logic [2:0]      refill_perm_i;

    logic            flush_i;
    logic            flush_done_o;

`ifdef TLB_ASID_EN
    logic [ASID_W-1:0] req_asid_i;
    logic [ASID_W-1:0] refill_asid_i;
    logic              flush_asid_valid_i;
    logic [ASID_W-1:0] flush_asid_i;
`endif

    modport master (
        output req_valid_i, req_vaddr_i, req_perm_i,
        output refill_valid_i, refill_vaddr_i, refill_paddr_i, refill_perm_i, flush_i,
`ifdef TLB_ASID_EN
        output req_asid_i, refill_asid_i, flush_asid_valid_i, flush_asid_i,
`endif
        input  req_ready_o, resp_valid_o, resp_hit_o, resp_paddr_o, resp_fault_o, flush_done_o
    );

    modport slave (
        input  req_valid_i, req_vaddr_i, req_perm_i,
        input  refill_valid_i, refill_vaddr_i, refill_paddr_i, refill_perm_i, flush_i,
`ifdef TLB_ASID_EN
        input  req_asid_i, refill_asid_i, flush_asid_valid_i, flush_asid_i,
`endif
        output req_ready_o, resp_valid_o, resp_hit_o, resp_paddr_o, resp_fault_o, flush_done_o
    );

endinterface

// File: rtl/tlb_rr_victim.sv
// Per-set round-robin victim pointers with lowest-invalid-way priority.
module tlb_rr_victim
    import mmu_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int WAYS  = 8,
    parameter int IDX_W = (SETS > 1) ? $clog2(SETS) : 1,
    parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [WAYS-1:0]  valid_vec,
    input  logic             advance,
    output logic [WAY_W-1:0] way,
    output logic             has_invalid
);

    logic [WAY_W-1:0] ptr_q [SETS];

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else if (advance) begin
            ptr_q[set_idx] <= ptr_q[set_idx] + WAY_W'(1);
        end
    end

    // Scan downwards so the lowest-numbered invalid way wins.
    always_comb begin
        // NOTE: defaults first so no path through the loop infers a latch.
        way         = ptr_q[set_idx];
        has_invalid = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) begin
                way         = WAY_W'(w);
                has_invalid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlb_l2_assoc.sv
// Set-associative L2 TLB with 1-cycle lookup, refill and set-serial flush.
// Defining TLB_ASID_EN adds ASID tagging and ASID-selective flush.
module tlb_l2_assoc
    import mmu_pkg::*;
#(
    parameter int ENTRIES    = 512,
    parameter int WAYS       = 8,
    parameter int VA_W       = 64,
    parameter int PA_W       = 64,
    parameter int PAGE_SHIFT = 12
) (
    input logic            clk,
    input logic            rst_n,
    tlb_l2_assoc_if.slave  bus
);

    localparam int SETS      = ENTRIES / WAYS;
    localparam int IDX_W     = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_SHIFT = PAGE_SHIFT + IDX_W;

    if (WAYS < 1 || (WAYS & (WAYS - 1)) != 0) begin : g_bad_ways
        $error("tlb_l2_assoc: WAYS must be a power of two");
    end
    if (ENTRIES % WAYS != 0) begin : g_bad_entries
        $error("tlb_l2_assoc: ENTRIES must be a multiple of WAYS");
    end
    if (VA_W <= TAG_SHIFT) begin : g_bad_va
        $error("tlb_l2_assoc: VA_W too small for page offset and index");
    end

    tlb_entry_t       mem_q [SETS][WAYS];
    tlb_state_e       state_q, state_d;
    logic [IDX_W-1:0] flush_idx_q;
    logic             ready, flush_done;
`ifdef TLB_ASID_EN
    logic              flush_asid_valid_q;
    logic [ASID_W-1:0] flush_asid_q;
`endif

    logic [IDX_W-1:0]     lk_set;
    logic [TAG_MAX_W-1:0] lk_tag;
    logic                 lk_hit, req_fire;
    logic [PPN_MAX_W-1:0] lk_ppn;
    logic [2:0]           lk_perm;

    assign lk_set   = IDX_W'(bus.req_vaddr_i >> PAGE_SHIFT);
    assign lk_tag   = TAG_MAX_W'(bus.req_vaddr_i >> TAG_SHIFT);
    assign req_fire = bus.req_valid_i && ready;

    always_comb begin
        lk_hit  = 1'b0;
        lk_ppn  = '0;
        lk_perm = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (mem_q[lk_set][w].valid && mem_q[lk_set][w].tag == lk_tag
`ifdef TLB_ASID_EN
                && mem_q[lk_set][w].asid == bus.req_asid_i
`endif
               ) begin
                lk_hit  = 1'b1;
                lk_ppn  = mem_q[lk_set][w].ppn;
                lk_perm = mem_q[lk_set][w].perm;
            end
        end
    end

    logic [IDX_W-1:0]     rf_set;
    logic [TAG_MAX_W-1:0] rf_tag;
    logic                 rf_fire, rf_hit, rf_has_invalid;
    logic [WAYS-1:0]      rf_valid_vec;
    logic [WAY_W-1:0]     rf_match_way, rf_victim_way, rf_way;
    tlb_entry_t           rf_entry;

    assign rf_set  = IDX_W'(bus.refill_vaddr_i >> PAGE_SHIFT);
    assign rf_tag  = TAG_MAX_W'(bus.refill_vaddr_i >> TAG_SHIFT);
    assign rf_fire = bus.refill_valid_i && (state_q == ST_IDLE);
    assign rf_way  = rf_hit ? rf_match_way : rf_victim_way;

    always_comb begin
        rf_hit       = 1'b0;
        rf_match_way = '0;
        rf_valid_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            rf_valid_vec[w] = mem_q[rf_set][w].valid;
            if (mem_q[rf_set][w].valid && mem_q[rf_set][w].tag == rf_tag
`ifdef TLB_ASID_EN
                && mem_q[rf_set][w].asid == bus.refill_asid_i
`endif
               ) begin
                rf_hit       = 1'b1;
                rf_match_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        rf_entry       = '0;
        rf_entry.valid = 1'b1;
        rf_entry.tag   = rf_tag;
        rf_entry.ppn   = PPN_MAX_W'(bus.refill_paddr_i >> PAGE_SHIFT);
        rf_entry.perm  = bus.refill_perm_i;
`ifdef TLB_ASID_EN
        rf_entry.asid  = bus.refill_asid_i;
`endif
    end

    tlb_rr_victim #(.SETS(SETS), .WAYS(WAYS), .IDX_W(IDX_W), .WAY_W(WAY_W)) u_victim (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_idx     (rf_set),
        .valid_vec   (rf_valid_vec),
        .advance     (rf_fire && !rf_hit && !rf_has_invalid),
        .way         (rf_victim_way),
        .has_invalid (rf_has_invalid)
    );

    // NOTE: only valid bits are reset; tag/PPN/perm are don't-care while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) mem_q[s][w].valid <= 1'b0;
        end else begin
            if (rf_fire) mem_q[rf_set][rf_way] <= rf_entry;
            if (state_q == ST_FLUSH) begin
                for (int w = 0; w < WAYS; w++) begin
`ifdef TLB_ASID_EN
                    if (!flush_asid_valid_q || mem_q[flush_idx_q][w].asid == flush_asid_q)
                        mem_q[flush_idx_q][w].valid <= 1'b0;
`else
                    mem_q[flush_idx_q][w].valid <= 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            flush_idx_q <= '0;
`ifdef TLB_ASID_EN
            flush_asid_valid_q <= 1'b0;
            flush_asid_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == ST_FLUSH) flush_idx_q <= flush_done ? '0 : flush_idx_q + IDX_W'(1);
`ifdef TLB_ASID_EN
            if (state_q == ST_IDLE && bus.flush_i) begin
                flush_asid_valid_q <= bus.flush_asid_valid_i;
                flush_asid_q       <= bus.flush_asid_i;
            end
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        ready      = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = !bus.flush_i;
                if (bus.flush_i) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_idx_q == IDX_W'(SETS - 1)) begin
                    flush_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered response; the array is read before this edge's writes land.
    logic            resp_valid_q, resp_hit_q, resp_fault_q;
    logic [PA_W-1:0] resp_paddr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_paddr_q <= '0;
        end else begin
            resp_valid_q <= req_fire;
            resp_hit_q   <= req_fire && lk_hit;
            resp_fault_q <= req_fire && lk_hit && |(bus.req_perm_i & ~lk_perm);
            resp_paddr_q <= (req_fire && lk_hit)
                          ? (PA_W'(lk_ppn << PAGE_SHIFT) | PA_W'(bus.req_vaddr_i[PAGE_SHIFT-1:0]))
                          : '0;
        end
    end

    assign bus.req_ready_o  = ready;
    assign bus.flush_done_o = flush_done;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_hit_o   = resp_hit_q;
    assign bus.resp_fault_o = resp_fault_q;
    assign bus.resp_paddr_o = resp_paddr_q;

endmodule

// File: tb/tb_tlb_l2_assoc.sv
// Randomized self-checking bench for tlb_l2_assoc against a per-VPN reference model.
// Builds with or without TLB_ASID_EN.
module tb_tlb_l2_assoc;
    import mmu_pkg::*;

    localparam int ENTRIES    = 512;
    localparam int WAYS       = 8;
    localparam int SETS       = ENTRIES / WAYS;
    localparam int PAGE_SHIFT = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tlb_l2_assoc_if #(.VA_W(64), .PA_W(64)) bus ();

    tlb_l2_assoc #(
        .ENTRIES(ENTRIES), .WAYS(WAYS), .VA_W(64), .PA_W(64), .PAGE_SHIFT(PAGE_SHIFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: each slot remembers the full VPN it translates.
    bit          m_valid [SETS][WAYS];
    logic [63:0] m_vpn   [SETS][WAYS];
    logic [63:0] m_ppn   [SETS][WAYS];
    logic [2:0]  m_perm  [SETS][WAYS];
    logic [15:0] m_asid  [SETS][WAYS];
    int          m_ptr   [SETS];
    logic [15:0] cur_asid = '0;
    bit          last_hit;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    function automatic void model_lookup(input logic [63:0] va, input logic [2:0] perm,
                                         output bit hit, output logic [63:0] pa, output bit fault);
        logic [63:0] vpn = va >> PAGE_SHIFT;
        int s = int'(vpn % SETS);
        hit = 1'b0; pa = '0; fault = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_vpn[s][w] == vpn && m_asid[s][w] == cur_asid) begin
                hit   = 1'b1;
                pa    = (m_ppn[s][w] << PAGE_SHIFT) + (va % 4096);
                fault = (perm & ~m_perm[s][w]) != 3'b000;
            end
        end
    endfunction

    function automatic void model_refill(input logic [63:0] va, input logic [63:0] pa, input logic [2:0] perm);
        logic [63:0] vpn = va >> PAGE_SHIFT;
        int s = int'(vpn % SETS);
        int way = -1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_vpn[s][w] == vpn && m_asid[s][w] == cur_asid) way = w;
        for (int w = 0; w < WAYS; w++)
            if (way < 0 && !m_valid[s][w]) way = w;
        if (way < 0) begin
            way      = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end
        m_valid[s][way] = 1'b1;
        m_vpn[s][way]   = vpn;
        m_ppn[s][way]   = pa >> PAGE_SHIFT;
        m_perm[s][way]  = perm;
        m_asid[s][way]  = cur_asid;
    endfunction

    function automatic void model_flush(input bit av, input logic [15:0] a);
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (!av || m_asid[s][w] == a) m_valid[s][w] = 1'b0;
    endfunction

    task automatic drive_idle();
        bus.req_valid_i    = 1'b0;
        bus.req_vaddr_i    = '0;
        bus.req_perm_i     = '0;
        bus.refill_valid_i = 1'b0;
        bus.refill_vaddr_i = '0;
        bus.refill_paddr_i = '0;
        bus.refill_perm_i  = '0;
        bus.flush_i        = 1'b0;
`ifdef TLB_ASID_EN
        bus.req_asid_i         = '0;
        bus.refill_asid_i      = '0;
        bus.flush_asid_valid_i = 1'b0;
        bus.flush_asid_i       = '0;
`endif
    endtask

    // One IDLE cycle: drive at negedge, check the response at the next negedge.
    task automatic step(input bit rv, input logic [63:0] va, input logic [2:0] perm,
                        input bit fv, input logic [63:0] fva, input logic [63:0] fpa,
                        input logic [2:0] fperm, input string tag);
        bit eh, ef;
        logic [63:0] ep;
        bus.req_valid_i    = rv;
        bus.req_vaddr_i    = va;
        bus.req_perm_i     = perm;
        bus.refill_valid_i = fv;
        bus.refill_vaddr_i = fva;
        bus.refill_paddr_i = fpa;
        bus.refill_perm_i  = fperm;
`ifdef TLB_ASID_EN
        bus.req_asid_i    = cur_asid;
        bus.refill_asid_i = cur_asid;
`endif
        #1;
        check({tag, "_ready"}, 64'(bus.req_ready_o), 64'd1);
        eh = 1'b0; ep = '0; ef = 1'b0;
        if (rv) model_lookup(va, perm, eh, ep, ef);
        if (fv) model_refill(fva, fpa, fperm);
        @(negedge clk);
        bus.req_valid_i    = 1'b0;
        bus.refill_valid_i = 1'b0;
        check({tag, "_rvalid"}, 64'(bus.resp_valid_o), 64'(rv));
        check({tag, "_hit"},    64'(bus.resp_hit_o),   64'(eh));
        check({tag, "_paddr"},  bus.resp_paddr_o,      ep);
        check({tag, "_fault"},  64'(bus.resp_fault_o), 64'(ef));
        last_hit = bus.resp_hit_o;
    endtask

    task automatic lookup(input logic [63:0] va, input logic [2:0] perm, input string tag);
        step(1'b1, va, perm, 1'b0, '0, '0, '0, tag);
    endtask

    task automatic refill(input logic [63:0] va, input logic [63:0] pa, input logic [2:0] perm, input string tag);
        step(1'b0, '0, '0, 1'b1, va, pa, perm, tag);
    endtask

    // Full sweep; a refill driven during the sweep must be dropped.
    task automatic do_flush(input bit av, input logic [15:0] a, input string tag);
        int cycles = 0;
        int dones  = 0;
        int done_at = -1;
        bus.flush_i = 1'b1;
`ifdef TLB_ASID_EN
        bus.flush_asid_valid_i = av;
        bus.flush_asid_i       = a;
`endif
        #1;
        check({tag, "_accept_ready"}, 64'(bus.req_ready_o), 64'd0);
        model_flush(av, a);
        @(negedge clk);
        bus.flush_i        = 1'b0;
        bus.refill_valid_i = 1'b1;
        bus.refill_vaddr_i = 64'h7000;
        bus.refill_paddr_i = 64'hdead_0000;
        bus.refill_perm_i  = 3'b111;
        #1;
        while (bus.req_ready_o === 1'b0 && cycles < 200) begin
            if (bus.flush_done_o === 1'b1) begin
                dones++;
                done_at = cycles;
            end
            cycles++;
            if (cycles == 10) bus.refill_valid_i = 1'b0;
            @(negedge clk);
            #1;
        end
        bus.refill_valid_i = 1'b0;
        check({tag, "_busy_cycles"}, 64'(cycles), 64'(SETS));
        check({tag, "_done_pulses"}, 64'(dones), 64'd1);
        check({tag, "_done_last"},   64'(done_at), 64'(SETS - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] va;
        int dones;

        drive_idle();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rvalid", 64'(bus.resp_valid_o), 64'd0);
        check("rst_hit",    64'(bus.resp_hit_o),   64'd0);
        check("rst_paddr",  bus.resp_paddr_o,      64'd0);
        check("rst_fault",  64'(bus.resp_fault_o), 64'd0);
        check("rst_done",   64'(bus.flush_done_o), 64'd0);
        check("rst_ready",  64'(bus.req_ready_o),  64'd1);

        // Basic hit, permission fault and unfilled miss
        refill(64'h1000, 64'h8000, PERM_R | PERM_W, "fill_basic");
        lookup(64'h1234, PERM_R, "hit_basic");
        check("hit_basic_const_paddr", bus.resp_paddr_o, 64'h8234);
        check("hit_basic_const_hit", 64'(last_hit), 64'd1);
        step(1'b0, '0, '0, 1'b0, '0, '0, '0, "idle_after_hit");
        lookup(64'h1234, PERM_X, "fault_x");
        check("fault_x_const", 64'(bus.resp_fault_o), 64'd1);
        lookup(64'h2000, PERM_R, "miss_unfilled");
        check("miss_unfilled_const_paddr", bus.resp_paddr_o, 64'd0);

        // Round-robin eviction in set 5 (VPN stride 64)
        for (int i = 1; i <= 9; i++)
            refill((64'(i) << 18) | 64'h5000, 64'(i + 100) << PAGE_SHIFT, 3'b111, "rr_fill");
        for (int i = 1; i <= 9; i++) begin
            lookup((64'(i) << 18) | 64'h5000, PERM_R, "rr_look9");
            check("rr_look9_const", 64'(last_hit), 64'(i != 1));
        end
        refill((64'd10 << 18) | 64'h5000, 64'd110 << PAGE_SHIFT, 3'b111, "rr_fill10");
        for (int i = 1; i <= 10; i++) begin
            lookup((64'(i) << 18) | 64'h5000, PERM_R, "rr_look10");
            check("rr_look10_const", 64'(last_hit), 64'(i != 1 && i != 2));
        end

        // Same-cycle lookup and refill: read-before-write
        va = (64'd16 << 18) | 64'h9abc;
        step(1'b1, va, PERM_R, 1'b1, va, 64'h55000, PERM_R | PERM_W, "same_cycle");
        check("same_cycle_const_miss", 64'(last_hit), 64'd0);
        lookup(va, PERM_R, "same_cycle_next");
        check("same_cycle_next_const", 64'(last_hit), 64'd1);

        // Randomized traffic on two sets with more VPNs than ways
        for (int n = 0; n < 400; n++) begin
            int k = int'($urandom_range(0, 11));
            logic [63:0] tagv = (k < 6) ? 64'(k) : (64'(k) << 40);
            logic [63:0] rva  = (tagv << 18) | (64'($urandom_range(10, 11)) << 12) | 64'($urandom_range(0, 4095));
            int k2 = int'($urandom_range(0, 11));
            logic [63:0] tag2 = (k2 < 6) ? 64'(k2) : (64'(k2) << 40);
            logic [63:0] fva  = (tag2 << 18) | (64'($urandom_range(10, 11)) << 12);
            logic [63:0] fpa  = {$urandom(), $urandom()} & ~64'hfff;
            step(1'(($urandom() & 3) != 0), rva, 3'($urandom()),
                 1'($urandom()), fva, fpa, 3'($urandom()), "rand");
        end

        // Lookup right before a full flush, then everything misses
        lookup(64'h1234, PERM_R, "pre_flush");
        do_flush(1'b0, '0, "flush_all");
        lookup(64'h1234, PERM_R, "post_flush_a");
        lookup((64'd3 << 18) | 64'h5000, PERM_R, "post_flush_b");
        lookup(64'h7000, PERM_R, "post_flush_ignored_refill");
        check("post_flush_const", 64'(last_hit), 64'd0);

        // Reset in the middle of a sweep
        refill(64'h1000, 64'h8000, 3'b111, "pre_rst_fill");
        refill(64'h4000, 64'h9000, 3'b111, "pre_rst_fill2");
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        dones = 0;
        repeat (10) begin
            if (bus.flush_done_o === 1'b1) dones++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_done", 64'(bus.flush_done_o), 64'd0);
        check("midrst_rvalid", 64'(bus.resp_valid_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SETS + 10) begin
            #1;
            if (bus.flush_done_o === 1'b1) dones++;
            @(negedge clk);
        end
        check("midrst_no_pulse", 64'(dones), 64'd0);
        lookup(64'h1000, PERM_R, "midrst_miss_a");
        lookup(64'h4000, PERM_R, "midrst_miss_b");
        check("midrst_miss_const", 64'(last_hit), 64'd0);

`ifdef TLB_ASID_EN
        // ASID-selective flush
        cur_asid = 16'd1;
        refill(64'h3000, 64'hA000, 3'b111, "asid1_fill");
        cur_asid = 16'd2;
        refill(64'h3000, 64'hB000, 3'b111, "asid2_fill");
        do_flush(1'b1, 16'd1, "flush_asid1");
        cur_asid = 16'd2;
        lookup(64'h3234, PERM_R, "asid2_hit");
        check("asid2_hit_const", bus.resp_paddr_o, 64'hB234);
        cur_asid = 16'd1;
        lookup(64'h3234, PERM_R, "asid1_miss");
        check("asid1_miss_const", 64'(last_hit), 64'd0);
        cur_asid = 16'd0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
